mux41_arbiter: RTL and testbench



---
 rtl/mux41_pkg.sv | 12 +
 rtl/mux41_rr_pick.sv | 29 ++
 rtl/mux41_arbiter.sv | 107 ++++++++++
 tb/tb_mux41_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/mux41_pkg.sv
// Shared types and helpers for the 4:1 mux round-robin arbiter.
package mux41_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {ST_IDLE, ST_GRANT} state_e;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    idx2onehot      = '0;
    idx2onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/mux41_rr_pick.sv
// Rotated priority search: first eligible request at ptr, ptr+1, ... (mod NUM_REQ).
module mux41_rr_pick
  import mux41_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);
  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   cand;

  assign elig = req & ~mask;

  // Scan farthest-first so the nearest eligible slot to ptr is the last write.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/mux41_arbiter.sv
// Round-robin owner/select controller for the shared 4:1 mux.
// Define MUX41_ARB_TIMEOUT_EN to force rotation after MAX_HOLD contested cycles.
module mux41_arbiter
  import mux41_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s0,
  output logic               s1,
  output logic               valid
);
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD out of range 2..255");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   own_q, own_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               take_new;

  // Excluding the owner only matters on timeout; on release req[own] is already low.
  assign pick_mask = (state_q == ST_GRANT) ? idx2onehot(own_q) : '0;

  mux41_rr_pick u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .mask (pick_mask),
    .found(pick_found),
    .idx  (pick_idx)
  );

`ifdef MUX41_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    take_new = 1'b0;
`ifdef MUX41_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      ST_IDLE: take_new = pick_found;
      ST_GRANT: begin
        if (!req[own_q]) begin
          if (pick_found) take_new = 1'b1;
          else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end
`ifdef MUX41_ARB_TIMEOUT_EN
        else if (hold_cnt_q == HOLD_LAST) take_new = pick_found;
        else hold_cnt_d = hold_cnt_q + 8'd1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if (take_new) begin
      state_d = ST_GRANT;
      own_d   = pick_idx;
      gnt_d   = idx2onehot(pick_idx);
      ptr_d   = pick_idx + IDX_W'(1);
`ifdef MUX41_ARB_TIMEOUT_EN
      hold_cnt_d = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
`ifdef MUX41_ARB_TIMEOUT_EN
      hold_cnt_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
`ifdef MUX41_ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  // own_q is kept through IDLE so the mux output stays on the last owner.
  assign gnt   = gnt_q;
  assign s1    = own_q[1];
  assign s0    = own_q[0];
  assign valid = |gnt_q;
endmodule

// File: tb/tb_mux41_arbiter.sv
// Directed checks for mux41_arbiter (MAX_HOLD=4), both timeout build options.
module tb_mux41_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s0, s1, valid;
  int         n_cmp = 0;
  int         n_bad = 0;

  mux41_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .s0(s0), .s1(s1), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [3:0] g_exp, input logic [1:0] s_exp,
                       input logic v_exp);
    n_cmp++;
    assert (gnt === g_exp && {s1, s0} === s_exp && valid === v_exp)
    else begin
      n_bad++;
      $error("FAIL %s: gnt=%b sel=%b valid=%b, want gnt=%b sel=%b valid=%b",
             tag, gnt, {s1, s0}, valid, g_exp, s_exp, v_exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    @(negedge clk);
    // Reset held 3 cycles with all requests up
    tick(); tick(); tick();
    check("reset", 4'b0000, 2'b00, 1'b0);

    // Single request and release; selects hold the last owner
    rst_n = 1'b1; req = 4'b0100; tick();
    check("single_gnt", 4'b0100, 2'b10, 1'b1);
    req = 4'b0000; tick();
    check("single_rel", 4'b0000, 2'b10, 1'b0);
    tick();
    check("idle_hold", 4'b0000, 2'b10, 1'b0);

    // Rotation 0,1,2,3,0 from a fresh pointer
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 4'b1111; tick();
    check("rot0", 4'b0001, 2'b00, 1'b1);
    req = 4'b1110; tick();
    check("rot1", 4'b0010, 2'b01, 1'b1);
    req = 4'b1101; tick();
    check("rot2", 4'b0100, 2'b10, 1'b1);
    req = 4'b1011; tick();
    check("rot3", 4'b1000, 2'b11, 1'b1);
    req = 4'b0111; tick();
    check("rot_wrap", 4'b0001, 2'b00, 1'b1);

    // Owner 1 with req=0011, then release of req[1]: no zero cycle
    req = 4'b0010; tick();
    check("bub_own1", 4'b0010, 2'b01, 1'b1);
    req = 4'b0011; tick();
    check("bub_hold1", 4'b0010, 2'b01, 1'b1);
    req = 4'b0001; tick();
    check("bub_hand0", 4'b0001, 2'b00, 1'b1);

    // Contested hold with req=1001
    rst_n = 1'b0; req = 4'b0000; tick(); rst_n = 1'b1;
    req = 4'b1001;
    for (int k = 1; k <= 10; k++) begin
      tick();
`ifdef MUX41_ARB_TIMEOUT_EN
      if ((((k - 1) / 4) % 2) == 0) check($sformatf("tmo_c%0d", k), 4'b0001, 2'b00, 1'b1);
      else                          check($sformatf("tmo_c%0d", k), 4'b1000, 2'b11, 1'b1);
`else
      check($sformatf("hold_c%0d", k), 4'b0001, 2'b00, 1'b1);
`endif
    end

    // Reset while owner 2 is active, then pointer restarts at 0
    rst_n = 1'b0; req = 4'b0000; tick(); rst_n = 1'b1;
    req = 4'b0100; tick();
    check("mid_own2", 4'b0100, 2'b10, 1'b1);
    rst_n = 1'b0; req = 4'b0110; tick();
    check("mid_rst", 4'b0000, 2'b00, 1'b0);
    rst_n = 1'b1; tick();
    check("mid_regnt", 4'b0010, 2'b01, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
